// File: rtl/maze_pkg.sv
// ============================================================================
// Module      : maze_pkg
// Description : Shared types and helpers for the micro-maze autopilot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maze_pkg;

    typedef enum logic [1:0] {
        HEAD_N = 2'd0,
        HEAD_E = 2'd1,
        HEAD_S = 2'd2,
        HEAD_W = 2'd3
    } heading_t;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_DECIDE = 3'd2,
        ST_PRESS  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [3:0] heading_to_btn(input heading_t h);
        logic [3:0] b;
        b = 4'b0000;
        case (h)
            HEAD_N:  b[BTN_UP]    = 1'b1;
            HEAD_S:  b[BTN_DOWN]  = 1'b1;
            HEAD_W:  b[BTN_LEFT]  = 1'b1;
            default: b[BTN_RIGHT] = 1'b1;
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/maze_dir_pick.sv
// ============================================================================
// Module      : maze_dir_pick
// Description : Right-hand-rule direction chooser (right, straight, left, back).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_dir_pick
    import maze_pkg::*;
(
    input  logic [1:0] i_heading,
    input  logic       i_wall_top,
    input  logic       i_wall_bottom,
    input  logic       i_wall_left,
    input  logic       i_wall_right,
    output logic [1:0] o_heading,
    output logic       o_valid
);

    // Walls indexed by absolute heading: N, E, S, W
    logic [3:0] w_closed;
    logic [1:0] w_cand [4];

    assign w_closed  = {i_wall_left, i_wall_bottom, i_wall_right, i_wall_top};
    assign w_cand[0] = i_heading + 2'd1;
    assign w_cand[1] = i_heading;
    assign w_cand[2] = i_heading + 2'd3;
    assign w_cand[3] = i_heading + 2'd2;

    always_comb begin
        o_heading = i_heading;
        o_valid   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!o_valid && !w_closed[w_cand[k]]) begin
                o_heading = w_cand[k];
                o_valid   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/maze_autopilot.sv
// ============================================================================
// Module      : maze_autopilot
// Description : Wall-following maze player driving single-cycle button presses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_autopilot
    import maze_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int GAP_CYCLES    = 0,
    parameter int MOVE_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic              i_wall_top,
    input  logic              i_wall_bottom,
    input  logic              i_wall_left,
    input  logic              i_wall_right,
    input  logic              i_win,
    output logic [3:0]        o_btn,
    output logic [MOVE_W-1:0] o_moves,
    output logic              o_busy,
    output logic              o_done
);

    localparam int c_SETTLE_TOTAL = SETTLE_CYCLES + GAP_CYCLES;
    localparam int c_CNT_W        = $clog2(c_SETTLE_TOTAL + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_SETTLE_TOTAL - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    heading_t            r_heading;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [3:0]          r_btn;
    logic [3:0]          w_btn_nxt;
    logic [MOVE_W-1:0]   r_moves;
    logic                r_busy;
    logic                r_done;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_moves_inc;
    logic                w_heading_ld;
    logic [1:0]          w_pick_heading;
    logic                w_pick_valid;

    maze_dir_pick u_dir_pick (
        .i_heading     (r_heading),
        .i_wall_top    (i_wall_top),
        .i_wall_bottom (i_wall_bottom),
        .i_wall_left   (i_wall_left),
        .i_wall_right  (i_wall_right),
        .o_heading     (w_pick_heading),
        .o_valid       (w_pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Win outranks pause, so a goal reached just before a pause still latches done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && !r_done) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (i_win) begin
                    w_state_nxt = ST_DONE;
                end else if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_pick_valid) begin
                    w_state_nxt = ST_PRESS;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_PRESS: begin
                w_state_nxt = i_enable ? ST_SETTLE : ST_IDLE;
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registers line up with it
    always_comb begin
        w_btn_nxt    = 4'b0000;
        w_moves_inc  = 1'b0;
        w_heading_ld = 1'b0;
        w_cnt_nxt    = '0;
        w_done_nxt   = r_done || (w_state_nxt == ST_DONE);
        w_busy_nxt   = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
        if ((r_state == ST_SETTLE) && (w_state_nxt == ST_SETTLE)) begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
        if (w_state_nxt == ST_PRESS) begin
            w_btn_nxt    = heading_to_btn(heading_t'(w_pick_heading));
            w_moves_inc  = 1'b1;
            w_heading_ld = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_heading <= HEAD_E;
            r_cnt     <= '0;
            r_btn     <= 4'b0000;
            r_moves   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_btn  <= w_btn_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_heading_ld) begin
                r_heading <= heading_t'(w_pick_heading);
            end
            if (w_moves_inc && (r_moves != {MOVE_W{1'b1}})) begin
                r_moves <= r_moves + MOVE_W'(1);
            end
        end
    end

    assign o_btn   = r_btn;
    assign o_moves = r_moves;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_maze_autopilot.sv
// ============================================================================
// Module      : tb_maze_autopilot
// Description : Scoreboard bench: directed wall patterns plus closed-loop maze game.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_maze_autopilot;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       d_top = 1'b0, d_bottom = 1'b0, d_left = 1'b0, d_right = 1'b0, d_win = 1'b0;
    logic       g_top, g_bottom, g_left, g_right, g_win;
    logic       closed_loop = 1'b0;
    logic       game_rst = 1'b1;
    logic       w_top, w_bottom, w_left, w_right, w_win;
    logic [3:0] btn;
    logic [7:0] moves;
    logic       busy, done;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_press = 0;
    logic [3:0] exp_q [$];
    logic [3:0] prev_btn = 4'b0000;
    logic [3:0] mon_exp;

    logic [3:0] cell_open [10][10];   // bit per direction N,E,S,W: 1 = passage
    int         gx, gy;
    logic       g_phase;

    always #5 clk = ~clk;

    assign w_top    = closed_loop ? g_top    : d_top;
    assign w_bottom = closed_loop ? g_bottom : d_bottom;
    assign w_left   = closed_loop ? g_left   : d_left;
    assign w_right  = closed_loop ? g_right  : d_right;
    assign w_win    = closed_loop ? g_win    : d_win;

    maze_autopilot #(.SETTLE_CYCLES(4), .GAP_CYCLES(0), .MOVE_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (enable),
        .i_wall_top    (w_top),
        .i_wall_bottom (w_bottom),
        .i_wall_left   (w_left),
        .i_wall_right  (w_right),
        .i_win         (w_win),
        .o_btn         (btn),
        .o_moves       (moves),
        .o_busy        (busy),
        .o_done        (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int dxf(input int d);
        return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
    endfunction

    function automatic int dyf(input int d);
        return (d == 2) ? 1 : ((d == 0) ? -1 : 0);
    endfunction

    function automatic logic [3:0] dir_to_btn(input int d);
        case (d)
            0:       return 4'b0001;
            1:       return 4'b1000;
            2:       return 4'b0010;
            default: return 4'b0100;
        endcase
    endfunction

    function automatic int btn_to_dir(input logic [3:0] b);
        case (b)
            4'b0001: return 0;
            4'b1000: return 1;
            4'b0010: return 2;
            4'b0100: return 3;
            default: return -1;
        endcase
    endfunction

    // Scoreboard monitor: every press must match the next queued expectation
    always @(negedge clk) begin
        if (!rst && (btn !== 4'b0000)) begin
            n_press = n_press + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_press", {28'd0, btn}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("press_dir", {28'd0, btn}, {28'd0, mon_exp});
            end
            check("press_no_hold", {28'd0, prev_btn}, 32'd0);
            check("moves_count", {24'd0, moves}, (n_press > 255) ? 32'd255 : n_press);
        end
        prev_btn = btn;
    end

    // Game model: position moves on the press edge, walls/win refresh every other cycle
    always @(posedge clk) begin
        int d;
        if (game_rst) begin
            gx <= 0; gy <= 0; g_phase <= 1'b0;
            g_top <= 1'b1; g_bottom <= 1'b1; g_left <= 1'b1; g_right <= 1'b1; g_win <= 1'b0;
        end else if (closed_loop) begin
            g_phase <= ~g_phase;
            if (btn !== 4'b0000) begin
                d = btn_to_dir(btn);
                n_tests++;
                if (d >= 0 && cell_open[gx][gy][d]) begin
                    gx <= gx + dxf(d);
                    gy <= gy + dyf(d);
                end else begin
                    n_fail++;
                    $display("FAIL press_ignored: btn %b at (%0d,%0d), expected a move through an open side", btn, gx, gy);
                end
            end
            if (g_phase) begin
                g_top    <= !cell_open[gx][gy][0];
                g_right  <= !cell_open[gx][gy][1];
                g_bottom <= !cell_open[gx][gy][2];
                g_left   <= !cell_open[gx][gy][3];
                g_win    <= (gx == 9) && (gy == 9);
            end
        end
    end

    // Random perfect maze via depth-first carving
    task automatic build_maze();
        bit visited [10][10];
        int stk [$];
        int nb [$];
        int c, x, y, d, nx, ny;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++) begin
                cell_open[i][j] = 4'b0000;
                visited[i][j]   = 1'b0;
            end
        visited[0][0] = 1'b1;
        stk.push_back(0);
        while (stk.size() > 0) begin
            c = stk[stk.size()-1];
            x = c / 10;
            y = c % 10;
            nb.delete();
            if (y > 0 && !visited[x][y-1]) nb.push_back(0);
            if (x < 9 && !visited[x+1][y]) nb.push_back(1);
            if (y < 9 && !visited[x][y+1]) nb.push_back(2);
            if (x > 0 && !visited[x-1][y]) nb.push_back(3);
            if (nb.size() == 0) begin
                void'(stk.pop_back());
            end else begin
                d  = nb[$urandom_range(nb.size()-1)];
                nx = x + dxf(d);
                ny = y + dyf(d);
                cell_open[x][y][d]            = 1'b1;
                cell_open[nx][ny][(d + 2) % 4] = 1'b1;
                visited[nx][ny] = 1'b1;
                stk.push_back(nx * 10 + ny);
            end
        end
    endtask

    // Reference walk: right-hand rule from (0,0) facing east to (9,9)
    task automatic build_path(output int len);
        int offs [4] = '{1, 0, 3, 2};
        int x, y, h, d, nd;
        bit found;
        x = 0; y = 0; h = 1; len = 0;
        while (!(x == 9 && y == 9) && len < 1000) begin
            found = 1'b0;
            nd    = h;
            for (int k = 0; k < 4; k++) begin
                d = (h + offs[k]) % 4;
                if (!found && cell_open[x][y][d]) begin
                    found = 1'b1;
                    nd    = d;
                end
            end
            if (!found) break;
            h = nd;
            x = x + dxf(h);
            y = y + dyf(h);
            exp_q.push_back(dir_to_btn(h));
            len++;
        end
    endtask

    task automatic wait_press(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (btn === 4'b0000 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (btn === 4'b0000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no press within 200 cycles, expected one", name);
        end
        #1;
    endtask

    initial begin
        int path_len, cyc;
        bit paused;

        // Reset with enable held high
        enable = 1'b1;
        d_bottom = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_btn",   {28'd0, btn}, 32'd0);
        check("rst_moves", {24'd0, moves}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Heading E, right (S) blocked: straight east
        exp_q.push_back(4'b1000);
        wait_press("straight_e");
        check("busy_running", {31'd0, busy}, 32'd1);

        // Dead end facing E: reverse to W, then right-of-W (N) when open
        d_top = 1'b1; d_bottom = 1'b1; d_right = 1'b1; d_left = 1'b0;
        exp_q.push_back(4'b0100);
        wait_press("reverse_w");
        d_top = 1'b0; d_bottom = 1'b0; d_right = 1'b0; d_left = 1'b0;
        exp_q.push_back(4'b0001);
        wait_press("right_of_w");

        // All walls closed: several decide rounds without pressing
        d_top = 1'b1; d_bottom = 1'b1; d_right = 1'b1; d_left = 1'b1;
        repeat (25) @(negedge clk);
        check("blocked_moves", {24'd0, moves}, 32'd3);
        check("blocked_btn",   {28'd0, btn}, 32'd0);
        d_top = 1'b0;
        exp_q.push_back(4'b0001);
        wait_press("top_open");

        // Win raised during settle
        d_win = 1'b1;
        repeat (10) @(negedge clk);
        check("win_done", {31'd0, done}, 32'd1);
        check("win_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("done_sticky", {31'd0, done}, 32'd1);
        check("done_moves",  {24'd0, moves}, 32'd4);
        check("directed_queue_drained", exp_q.size(), 32'd0);

        // Closed loop against the game model
        rst = 1'b1; game_rst = 1'b1; enable = 1'b0; d_win = 1'b0;
        closed_loop = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_clears_done", {31'd0, done}, 32'd0);
        check("rst_clears_moves", {24'd0, moves}, 32'd0);
        n_press = 0;
        exp_q.delete();
        build_maze();
        build_path(path_len);
        rst = 1'b0; game_rst = 1'b0; enable = 1'b1;
        cyc = 0;
        paused = 1'b0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            #1;
            cyc++;
            if (n_press == 10 && !paused) begin
                enable = 1'b0;
                repeat (20) @(negedge clk);
                #1;
                check("pause_no_press", n_press, 32'd10);
                check("pause_idle", {31'd0, busy}, 32'd0);
                enable = 1'b1;
                paused = 1'b1;
                cyc += 20;
            end
        end
        check("loop_done",  {31'd0, done}, 32'd1);
        check("loop_x",     gx, 32'd9);
        check("loop_y",     gy, 32'd9);
        check("loop_queue", exp_q.size(), 32'd0);
        check("loop_moves", {24'd0, moves}, (path_len > 255) ? 32'd255 : path_len);
        repeat (20) @(negedge clk);
        check("loop_done_hold", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
